// File: rtl/quad_mux_operand_sequencer_pkg.sv
// Shared state encoding and default phase length for the quad mux operand sequencer.
package quad_mux_operand_sequencer_pkg;
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] GOT_A = 2'd1;
   localparam logic [1:0] ARMED = 2'd2;
   localparam logic [1:0] SCAN  = 2'd3;
   localparam int TICK_DIV_DEFAULT = 4;
endpackage

// File: rtl/quad_mux_operand_sequencer_phase_tick_counter.sv
// Free-running phase counter; tick pulses on the terminal count while enabled.
module phase_tick_counter
   import quad_mux_operand_sequencer_pkg::*;
#(
   parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tick
);
   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] TC = CW'(TICK_DIV - 1);

   if (TICK_DIV < 1 || TICK_DIV > 65535) begin : g_bad_tick_div
      $error("phase_tick_counter: TICK_DIV must be in 1..65535");
   end

   logic [CW-1:0] cnt_q, cnt_d;

   assign tick = en && (cnt_q == TC);

   always_comb begin
      cnt_d = cnt_q;
      if (clr)     cnt_d = '0;
      else if (en) cnt_d = tick ? '0 : cnt_q + CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
endmodule

// File: rtl/quad_mux_operand_sequencer.sv
// Loads two operands over a valid/ready handshake, then scans the mux select A,B,A,B
// with each select level held for TICK_DIV cycles.
module quad_mux_operand_sequencer
   import quad_mux_operand_sequencer_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] data_in,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic             start,
   input  logic             stop,
   input  logic             clear,
   output logic [WIDTH-1:0] A,
   output logic [WIDTH-1:0] B,
   output logic             S,
   output logic             E,
   output logic             busy
);
   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic             s_q, s_d, e_q, e_d, busy_q, busy_d;
   logic             tick;

   // Counter is held at zero whenever the next cycle is not a scan cycle, so
   // every entry into SCAN starts a full-length phase.
   phase_tick_counter #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (state_d != SCAN),
      .en   (state_q == SCAN),
      .tick (tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= 1'b0;
         e_q     <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         s_q     <= s_d;
         e_q     <= e_d;
         busy_q  <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (clear) state_d = IDLE;
      else begin
         case (state_q)
            IDLE:    if (load_valid) state_d = GOT_A;
            GOT_A:   if (load_valid) state_d = ARMED;
            ARMED:   if (start)      state_d = SCAN;
            default: if (stop)       state_d = ARMED;
         endcase
      end
   end

   always_comb begin
      a_d    = a_q;
      b_d    = b_q;
      if (!clear && load_valid) begin
         if (state_q == IDLE)  a_d = data_in;
         if (state_q == GOT_A) b_d = data_in;
      end
      e_d    = (state_d != SCAN);
      busy_d = (state_d == SCAN);
      // Only a continuing scan may toggle; entry, stop and clear all force S low.
      s_d    = (state_q == SCAN && state_d == SCAN) ? (s_q ^ tick) : 1'b0;
   end

   assign load_ready = (state_q == IDLE) || (state_q == GOT_A);
   assign A          = a_q;
   assign B          = b_q;
   assign S          = s_q;
   assign E          = e_q;
   assign busy       = busy_q;
endmodule

// File: tb/tb_quad_mux_operand_sequencer.sv
// Directed bench for the quad mux operand sequencer (TICK_DIV=4 and TICK_DIV=1 builds).
module tb_quad_mux_operand_sequencer;
   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] data_in, d1_data_in;
   logic       load_valid, start, stop, clear;
   logic       d1_load_valid, d1_start, d1_stop, d1_clear;
   logic       load_ready, S, E, busy;
   logic [3:0] A, B;
   logic       d1_load_ready, d1_S, d1_E, d1_busy;
   logic [3:0] d1_A, d1_B;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   quad_mux_operand_sequencer #(.WIDTH(4), .TICK_DIV(4)) dut (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .load_valid(load_valid),
      .load_ready(load_ready), .start(start), .stop(stop), .clear(clear),
      .A(A), .B(B), .S(S), .E(E), .busy(busy)
   );

   quad_mux_operand_sequencer #(.WIDTH(4), .TICK_DIV(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .data_in(d1_data_in), .load_valid(d1_load_valid),
      .load_ready(d1_load_ready), .start(d1_start), .stop(d1_stop), .clear(d1_clear),
      .A(d1_A), .B(d1_B), .S(d1_S), .E(d1_E), .busy(d1_busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b1;
      data_in = '0; load_valid = 0; start = 0; stop = 0; clear = 0;
      d1_data_in = '0; d1_load_valid = 0; d1_start = 0; d1_stop = 0; d1_clear = 0;

      // asynchronous reset mid-cycle, observed before any clock edge
      #2 rst_n = 1'b0;
      #1;
      chk("rst_A", 32'(A), 32'h0);
      chk("rst_B", 32'(B), 32'h0);
      chk("rst_S", 32'(S), 32'h0);
      chk("rst_E", 32'(E), 32'h1);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_ready", 32'(load_ready), 32'h1);
      #9 rst_n = 1'b1;
      step();

      // load A then B
      load_valid = 1; data_in = 4'hA;
      step();
      chk("load_A", 32'(A), 32'hA);
      chk("gota_ready", 32'(load_ready), 32'h1);
      data_in = 4'h5;
      step();
      chk("load_B", 32'(B), 32'h5);
      chk("armed_ready", 32'(load_ready), 32'h0);
      chk("armed_E", 32'(E), 32'h1);
      chk("armed_S", 32'(S), 32'h0);

      // back-pressure: operand dropped while ARMED
      data_in = 4'hF;
      step();
      chk("bp_A", 32'(A), 32'hA);
      chk("bp_B", 32'(B), 32'h5);
      chk("bp_ready", 32'(load_ready), 32'h0);
      load_valid = 0;

      // start and scan: S = 0000 1111 0000 ...
      start = 1;
      step();
      start = 0;
      chk("scan_E", 32'(E), 32'h0);
      chk("scan_busy", 32'(busy), 32'h1);
      for (int k = 0; k < 12; k++) begin
         if (k > 0) step();
         chk($sformatf("scan_S_%0d", k), 32'(S), 32'((k / 4) % 2));
      end

      // stop on the cycle S would toggle 0->1
      stop = 1;
      step();
      stop = 0;
      chk("stop_E", 32'(E), 32'h1);
      chk("stop_S", 32'(S), 32'h0);
      chk("stop_busy", 32'(busy), 32'h0);
      chk("stop_ready", 32'(load_ready), 32'h0);

      // restart without reloading: full first phase
      start = 1;
      step();
      start = 0;
      chk("restart_E", 32'(E), 32'h0);
      for (int k = 0; k < 8; k++) begin
         if (k > 0) step();
         chk($sformatf("rescan_S_%0d", k), 32'(S), 32'((k / 4) % 2));
      end

      // clear beats stop and start
      clear = 1; stop = 1; start = 1;
      step();
      clear = 0; stop = 0; start = 0;
      chk("clr_ready", 32'(load_ready), 32'h1);
      chk("clr_E", 32'(E), 32'h1);
      chk("clr_S", 32'(S), 32'h0);
      chk("clr_busy", 32'(busy), 32'h0);
      chk("clr_A", 32'(A), 32'hA);
      chk("clr_B", 32'(B), 32'h5);

      // clear with load_valid in IDLE: no capture
      clear = 1; load_valid = 1; data_in = 4'h3;
      step();
      clear = 0;
      chk("clrload_A", 32'(A), 32'hA);
      chk("clrload_ready", 32'(load_ready), 32'h1);

      // reload and reset mid-scan
      step();
      chk("reload_A", 32'(A), 32'h3);
      data_in = 4'hC;
      step();
      load_valid = 0;
      chk("reload_B", 32'(B), 32'hC);
      start = 1;
      step();
      start = 0;
      step();
      chk("pre_rst_busy", 32'(busy), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_A", 32'(A), 32'h0);
      chk("midrst_B", 32'(B), 32'h0);
      chk("midrst_E", 32'(E), 32'h1);
      chk("midrst_S", 32'(S), 32'h0);
      chk("midrst_busy", 32'(busy), 32'h0);
      chk("midrst_ready", 32'(load_ready), 32'h1);
      step();
      rst_n = 1'b1;
      step();

      // TICK_DIV=1 build: S alternates every cycle
      d1_load_valid = 1; d1_data_in = 4'h3;
      step();
      d1_data_in = 4'hC;
      step();
      d1_load_valid = 0;
      d1_start = 1;
      step();
      d1_start = 0;
      chk("t1_A", 32'(d1_A), 32'h3);
      chk("t1_B", 32'(d1_B), 32'hC);
      chk("t1_E", 32'(d1_E), 32'h0);
      for (int k = 0; k < 6; k++) begin
         if (k > 0) step();
         chk($sformatf("t1_S_%0d", k), 32'(d1_S), 32'(k % 2));
      end
      chk("t1_busy", 32'(d1_busy), 32'h1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
